// File: rtl/sid_pkg.sv
// sid_pkg: shared definitions for the SID bus arbiter slice.
//   ADDR_W / DATA_W : SID register port widths
//   SID_REG_LAST    : highest implemented SID register address
//   sid_wr_t        : one queued register write {addr, data}
//   sid_state_t     : arbiter FSM state encoding
package sid_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] SID_REG_LAST = 5'h18;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sid_wr_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sid_state_t;

endpackage

// File: rtl/sid_wr_fifo.sv
// sid_wr_fifo: small synchronous FIFO of SID register writes.
//   clk32, reset_n   : clock, asynchronous active-low reset (flushes FIFO)
//   push, push_entry : write an entry (caller guarantees !full)
//   pop              : drop the head entry (caller guarantees !empty)
//   head_entry       : current head, valid whenever !empty
//   full, empty      : occupancy flags, derived from registered pointers
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk32,
    input  logic    reset_n,
    input  logic    push,
    input  sid_wr_t push_entry,
    input  logic    pop,
    output sid_wr_t head_entry,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sid_wr_t        mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign head_entry = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk32) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/sid_bus_arbiter.sv
// sid_bus_arbiter: shares the SID register port between the CPU, a host
// write FIFO and a register clear sequencer.
//   clk32, reset_n                         : clock, async active-low reset
//   cpu_cs/cpu_we/cpu_addr/cpu_din         : CPU access, always wins, zero latency
//   cpu_dout                               : SID read data straight back to CPU
//   host_valid/host_ready/host_addr/host_data : host write push interface
//   clear_req/clear_busy/clear_done        : clear sequence control/status
//   sid_cs/sid_we/sid_addr/sid_din/sid_dout: SID register port
// Non-CPU writes are spaced at least GAP_CYCLES apart.
module sid_bus_arbiter
    import sid_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                GAP_CYCLES = 32,
    parameter logic [ADDR_W-1:0] CLR_LAST   = SID_REG_LAST
) (
    input  logic              clk32,
    input  logic              reset_n,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              sid_cs,
    output logic              sid_we,
    output logic [ADDR_W-1:0] sid_addr,
    output logic [DATA_W-1:0] sid_din,
    input  logic [DATA_W-1:0] sid_dout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sid_state_t         state_reg;
    logic [ADDR_W-1:0]  clr_addr_reg;
    logic               clear_busy_reg;
    logic               clear_done_reg;
    logic [GAP_W-1:0]   gap_reg;

    sid_wr_t            head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               src_avail;
    logic               arb_issue;
    logic [ADDR_W-1:0]  arb_addr;
    logic [DATA_W-1:0]  arb_data;

    // Ready comes from registered occupancy only, so a push into a full
    // FIFO is refused even if a pop happens in the same cycle.
    assign host_ready = !fifo_full;
    assign fifo_push  = host_valid && host_ready;

    sid_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry ({host_addr, host_data}),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // While clearing, the FIFO is held; it only drains from IDLE.
    assign src_avail = (state_reg == ST_CLEAR) || !fifo_empty;
    assign arb_issue = !cpu_cs && (gap_reg == '0) && src_avail;
    assign fifo_pop  = arb_issue && (state_reg == ST_IDLE);

    assign arb_addr = (state_reg == ST_CLEAR) ? clr_addr_reg : head_entry.addr;
    assign arb_data = (state_reg == ST_CLEAR) ? '0 : head_entry.data;

    assign cpu_dout   = sid_dout;
    assign clear_busy = clear_busy_reg;
    assign clear_done = clear_done_reg;

    always_comb begin
        sid_cs   = 1'b0;
        sid_we   = 1'b0;
        sid_addr = '0;
        sid_din  = '0;
        if (cpu_cs) begin
            sid_cs   = 1'b1;
            sid_we   = cpu_we;
            sid_addr = cpu_addr;
            sid_din  = cpu_din;
        end else if (arb_issue) begin
            sid_cs   = 1'b1;
            sid_we   = 1'b1;
            sid_addr = arb_addr;
            sid_din  = arb_data;
        end
    end

    // Loading GAP_CYCLES-1 on issue at t makes the counter reach zero at
    // t+GAP_CYCLES, the next cycle an arbiter write may go out.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            gap_reg <= '0;
        end else if (arb_issue) begin
            gap_reg <= GAP_W'(GAP_CYCLES - 1);
        end else if (gap_reg != '0) begin
            gap_reg <= gap_reg - 1'b1;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            clr_addr_reg   <= '0;
            clear_busy_reg <= 1'b0;
            clear_done_reg <= 1'b0;
        end else begin
            clear_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A FIFO issue this same cycle still completes via fifo_pop.
                    if (clear_req) begin
                        state_reg      <= ST_CLEAR;
                        clr_addr_reg   <= '0;
                        clear_busy_reg <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (arb_issue) begin
                        clr_addr_reg <= clr_addr_reg + 1'b1;
                        if (clr_addr_reg == CLR_LAST) begin
                            state_reg      <= ST_IDLE;
                            clear_busy_reg <= 1'b0;
                            clear_done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    clear_busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
